// File: rtl/skewer_feed_controller_if.sv
// Control/handshake bundle between the NPU sequencer, the UB read port and the
// streaming skewer for one operand stream.
interface skewer_feed_controller_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  stall;
  logic                  ub_rd_en;
  logic [ADDR_WIDTH-1:0] ub_rd_addr;
  logic                  skew_en;
  logic                  feed_zero;
  logic                  skew_first_in;
  logic                  skew_last_in;
  logic                  skew_last_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, base_addr, len, stall, skew_last_out,
    input  ub_rd_en, ub_rd_addr, skew_en, feed_zero, skew_first_in, skew_last_in,
           busy, done, err
  );

  modport slave (
    input  start, base_addr, len, stall, skew_last_out,
    output ub_rd_en, ub_rd_addr, skew_en, feed_zero, skew_first_in, skew_last_in,
           busy, done, err
  );
endinterface

// File: rtl/skewer_feed_controller.sv
// Streams len UB vectors into the skewer, flushes it with zeros until last_out,
// drains the array wavefront and pulses done.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif

module skewer_feed_controller #(
  parameter int N            = `ARRAY_SIZE,
  parameter int ADDR_WIDTH   = 16,
  parameter int LEN_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 2*`ARRAY_SIZE-2
) (
  input logic                     clk,
  input logic                     rst,
  skewer_feed_controller_if.slave bus
);
  localparam int FW = $clog2(N+1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [FW-1:0]        FLUSH_LAST = FW'(N);
  localparam logic [DW-1:0]        DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES-1 : 0);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_WIDTH-1:0]  vec_idx_q, vec_idx_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic rd_en, feeding, last_vec, zero_phase;

  assign rd_en      = (state_q == S_FEED) && (rd_cnt_q < len_q) && !bus.stall;
  assign feeding    = (state_q == S_FEED) && valid_q && !bus.stall;
  assign last_vec   = (vec_idx_q == len_q - LEN_ONE);
  assign zero_phase = (state_q == S_FLUSH) || (state_q == S_DRAIN);

  // Outputs follow stall combinationally so a frozen cycle never strobes UB or skewer.
  assign bus.ub_rd_en      = rd_en;
  assign bus.ub_rd_addr    = rd_en ? base_q + ADDR_WIDTH'(rd_cnt_q) : '0;
  assign bus.skew_en       = feeding || (zero_phase && !bus.stall);
  assign bus.feed_zero     = ((state_q == S_FEED) && !valid_q) || zero_phase;
  assign bus.skew_first_in = feeding && (vec_idx_q == '0);
  assign bus.skew_last_in  = feeding && last_vec;
  assign bus.busy          = (state_q == S_FEED) || zero_phase;
  assign bus.done          = (state_q == S_DONE);
  assign bus.err           = err_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q;
    vec_idx_d   = vec_idx_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    valid_d     = valid_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        base_d      = bus.base_addr;
        len_d       = bus.len;
        err_d       = 1'b0;
        rd_cnt_d    = '0;
        vec_idx_d   = '0;
        flush_cnt_d = '0;
        drain_cnt_d = '0;
        valid_d     = 1'b0;
        state_d     = S_FEED;
      end
      S_FEED: if (!bus.stall) begin
        if (len_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          valid_d = rd_en;
          if (rd_en) rd_cnt_d = rd_cnt_q + LEN_ONE;
          if (valid_q) begin
            vec_idx_d = vec_idx_q + LEN_ONE;
            if (last_vec) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: if (!bus.stall) begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        // A skewer that never returns last_out must not hang the sequencer.
        if (bus.skew_last_out || flush_cnt_q == FLUSH_LAST) begin
          if (!bus.skew_last_out) err_d = 1'b1;
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: if (!bus.stall) begin
        drain_cnt_d = drain_cnt_q + DW'(1);
        if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      vec_idx_q   <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      vec_idx_q   <= vec_idx_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_skewer_feed_controller.sv
// Random/directed bench for skewer_feed_controller; expectations come from the
// nominal cycle schedule, stretched by one frozen cycle per stalled busy cycle.
module tb_skewer_feed_controller;
  localparam int N     = 4;
  localparam int DRAIN = 2*N-2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_err_g = 1'b0;

  skewer_feed_controller_if #(.ADDR_WIDTH(16), .LEN_WIDTH(16)) bus ();

  skewer_feed_controller #(
    .N(N), .ADDR_WIDTH(16), .LEN_WIDTH(16), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // {busy, done, rd_en, skew_en, feed_zero, first_in, last_in, err}
  task automatic check_cycle(input string tag, input logic [7:0] e, input logic [15:0] ea);
    chk(tag, {24'h0, bus.busy, bus.done, bus.ub_rd_en, bus.skew_en, bus.feed_zero,
              bus.skew_first_in, bus.skew_last_in, bus.err}, {24'h0, e});
    chk({tag, "_addr"}, {16'h0, bus.ub_rd_addr}, {16'h0, ea});
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  // k is the next un-stalled (active) cycle of the nominal schedule: reads at
  // 1..l, vectors at 2..l+1, flush of f cycles, then DRAIN, then done.
  task automatic run_op(input logic [15:0] b, input int l, input bit to,
                        input int spct, input logic [31:0] smask, input int abort_at);
    int k, c, f, n_end;
    bit act;
    logic [7:0]  e;
    logic [15:0] ea;
    f     = to ? N + 1 : N;
    n_end = (l == 0) ? 1 : l + 1 + f + DRAIN;
    bus.start = 1'b1; bus.base_addr = b; bus.len = 16'(l);
    bus.stall = 1'($urandom_range(0, 1)); bus.skew_last_out = 1'b0;
    @(negedge clk);
    check_cycle("idle", {7'b0, exp_err_g}, 16'h0);
    @(posedge clk); #1;
    k = 1; c = 1;
    while (k <= n_end + 1) begin
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.base_addr = 16'($urandom);
      bus.len       = 16'($urandom_range(0, 20));
      if (k > n_end) bus.stall = 1'($urandom_range(0, 1));
      else bus.stall = (c < 32 && smask[c]) || ($urandom_range(0, 99) < spct);
      if (l != 0 && !to && k == l + 1 + N) bus.skew_last_out = 1'b1;
      else if (l == 0 || k <= l + 1 || k > l + 1 + f) bus.skew_last_out = ($urandom_range(0, 7) == 0);
      else bus.skew_last_out = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_cycle("abort", 8'h0, 16'h0);
        exp_err_g = 1'b0;
        #1 rst = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.skew_last_out = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (k <= n_end) begin
        act  = !bus.stall;
        e[7] = 1'b1;
        e[6] = 1'b0;
        e[5] = act && k <= l;
        e[4] = act && k >= 2;
        e[3] = (k == 1) || (k >= l + 2);
        e[2] = act && l > 0 && k == 2;
        e[1] = act && l > 0 && k == l + 1;
        e[0] = to && k >= l + 2 + f;
        ea   = e[5] ? b + 16'(k - 1) : 16'h0;
        check_cycle("run", e, ea);
        if (act) k++;
      end else begin
        exp_err_g = (l == 0) || to;
        check_cycle("done", {7'b0100000, exp_err_g}, 16'h0);
        k++;
      end
      @(posedge clk); #1;
      c++;
      if (c > 2000) begin
        chk("cycle_budget", k, n_end + 2);
        break;
      end
    end
    bus.start = 1'b0; bus.stall = 1'b0; bus.skew_last_out = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.stall = 1'b0; bus.skew_last_out = 1'b0;
    @(negedge clk);
    check_cycle("reset", 8'h0, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0010, 4, 1'b0, 0, 32'h0,  0);  // nominal
    run_op(16'h0000, 1, 1'b0, 0, 32'h0,  0);  // single vector, both markers
    run_op(16'h0020, 4, 1'b0, 0, 32'h18, 0);  // stall in cycles 3-4
    run_op(16'h0030, 0, 1'b0, 0, 32'h0,  0);  // len 0 -> err
    run_op(16'h0040, 2, 1'b0, 0, 32'h0,  0);  // err cleared by next start
    run_op(16'h0050, 2, 1'b1, 0, 32'h0,  0);  // last_out never returns
    run_op(16'h0060, 8, 1'b0, 0, 32'h0,  3);  // reset mid-run
    run_op(16'h0060, 8, 1'b0, 0, 32'h0,  0);
    run_op(16'hFFFE, 4, 1'b0, 0, 32'h0,  0);  // address wrap
    for (int i = 0; i < 30; i++)
      run_op(16'($urandom), $urandom_range(0, 12), ($urandom_range(0, 5) == 0), 25, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/skewer_feed_controller.md
Name: skewer_feed_controller

Overview:
Sequences one operand stream into streaming_skewer. On `start`, it reads `len` consecutive vectors from the unified buffer (UB) and drives skewer `en` and the `first_in`/`last_in` markers aligned with the data. It then flushes the skewer with zeros until `last_out` returns, counts out the array drain, and pulses `done`. It sits between the top-level NPU control FSM and the UB-read → skewer datapath.

Parameters:
N, `ARRAY_SIZE, skewer depth; the skewer emits last_out N enabled cycles after last_in.
ADDR_WIDTH, 16, UB address width.
LEN_WIDTH, 16, width of the vector-count field.
DRAIN_CYCLES, 2*`ARRAY_SIZE-2, zero-fed cycles after last_out before done (array wavefront drain).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  launch pulse; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first UB address, latched at start
len  in  LEN_WIDTH  number of vectors, latched at start
stall  in  1  downstream backpressure; freezes sequencing
ub_rd_en  out  1  UB read strobe; 1-cycle read latency; UB output holds when not strobed
ub_rd_addr  out  ADDR_WIDTH  UB read address
skew_en  out  1  skewer enable
feed_zero  out  1  selects zero instead of UB data on skewer data_in
skew_first_in  out  1  marker, high with vector 0
skew_last_in  out  1  marker, high with vector len-1
skew_last_out  in  1  skewer last_out
busy  out  1  high outside IDLE/DONE
done  out  1  1-cycle completion pulse
err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, valid_q 0. A reset mid-operation aborts immediately; no done pulse is generated.
- States: IDLE → FEED → FLUSH → DRAIN → DONE → IDLE.
- IDLE: start=1 latches base_addr and len, clears err, and moves to FEED. If len==0: no reads are issued, err is set, and the block goes straight to DONE (done pulses the next cycle).
- start outside IDLE is ignored.
- FEED, with stall=0:
  - ub_rd_en=1 and ub_rd_addr=base+rd_cnt while rd_cnt<len.
  - valid_q is the registered ub_rd_en.
  - skew_en=valid_q, feed_zero=!valid_q.
  - skew_first_in=valid_q && vec_idx==0; skew_last_in=valid_q && vec_idx==len-1.
  - len==1: both markers are high in the same cycle.
- FEED exit: the cycle after last_in is consumed, move to FLUSH.
- FLUSH: skew_en=1, feed_zero=1, flush counter increments. skew_last_out=1 → DRAIN. If the counter reaches N+1 without last_out, set err and go to DRAIN anyway.
- DRAIN: skew_en=1, feed_zero=1 for DRAIN_CYCLES cycles, then DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- stall=1 in FEED/FLUSH/DRAIN freezes state, counters and valid_q, and forces ub_rd_en=0, skew_en=0 and both markers 0. The in-flight UB word is held by the UB output register and consumed once stall drops; markers re-present with it.
- stall in IDLE/DONE has no effect.
- Nominal timing (start sampled at end of cycle 0, no stall):
  - reads in cycles 1..L;
  - first_in in cycle 2; last_in in cycle L+1;
  - last_out in cycle L+1+N;
  - done in cycle L+2+N+DRAIN_CYCLES.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged on wrap.
- skew_last_out outside FLUSH is ignored.

Test Plan:
- N=4, DRAIN_CYCLES=6, base=0x10, len=4, no stall → reads 0x10..0x13 in cycles 1–4; first_in in cycle 2; last_in in cycle 5; last_out in cycle 9; done in cycle 16; busy high in cycles 1–15; err=0.
- len=1, base=0x00 → single read in cycle 1; first_in and last_in both high in cycle 2; done in cycle 13.
- len=4, stall high in cycles 3–4 → no reads or skew_en during the stall; vector 1 enters the skewer in cycle 5; last_in in cycle 7; done in cycle 18; exactly 4 reads issued.
- len=0 → no ub_rd_en; done in cycle 2; err=1. The next start with len=2 clears err.
- skew_last_out tied low, len=2 → err set after N+1 flush cycles; DRAIN still runs; done still pulses.
- rst asserted in cycle 3 of a len=8 run → all outputs 0 immediately; no done. A new start after rst drops runs a full sequence from base.
- base=0xFFFE, len=4 → read addresses FFFE, FFFF, 0000, 0001.
